// File: rtl/pad_cfg_pkg.sv
// Shared types and constants for the pad configuration sequencer:
// FSM state encoding, configuration-word field offsets and the default shadow value.
package pad_cfg_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_SHIFT_LO = 3'd1,
      ST_SHIFT_HI = 3'd2,
      ST_LOAD     = 3'd3,
      ST_DONE     = 3'd4
   } state_t;

   localparam int CFG_W = 13;

   localparam int OFS_MGMT_ENA    = 0;
   localparam int OFS_OEB         = 1;
   localparam int OFS_HOLDOVER    = 2;
   localparam int OFS_INP_DIS     = 3;
   localparam int OFS_IB_MODE_SEL = 4;
   localparam int OFS_ANALOG_EN   = 5;
   localparam int OFS_ANALOG_SEL  = 6;
   localparam int OFS_ANALOG_POL  = 7;
   localparam int OFS_SLOW_SEL    = 8;
   localparam int OFS_VTRIP_SEL   = 9;
   localparam int OFS_DM          = 10;
   localparam int DM_W            = 3;

   // Input enabled (inp_dis=0), output disabled (oeb=1), management-owned pad.
   localparam logic [CFG_W-1:0] RESET_CFG_DEFAULT =
      (CFG_W'(3'b110) << OFS_DM) |
      (CFG_W'(1)      << OFS_OEB) |
      (CFG_W'(1)      << OFS_MGMT_ENA);

endpackage

// File: rtl/pad_in_filter.sv
// One pad input: two-flop synchroniser, followed by an optional glitch filter
// enabled with `define PAD_INPUT_FILTER_EN.
module pad_in_filter
   import pad_cfg_pkg::*;
#(
   parameter int FILT_CYCLES = 3
) (
   input  logic clock,
   input  logic reset,
   input  logic raw,
   output logic filt
);

   logic sync_q1;
   logic sync_q2;

   if (FILT_CYCLES < 1) begin : g_bad_filt
      $error("pad_in_filter: FILT_CYCLES must be at least 1");
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync_q1 <= 1'b0;
         sync_q2 <= 1'b0;
      end else begin
         sync_q1 <= raw;
         sync_q2 <= sync_q1;
      end
   end

`ifdef PAD_INPUT_FILTER_EN
   localparam int FCNT_W = $clog2(FILT_CYCLES + 1);

   logic [FCNT_W-1:0] fcnt;

   // The output flips on the FILT_CYCLES-th consecutive differing sample.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         fcnt <= '0;
         filt <= 1'b0;
      end else if (sync_q2 == filt) begin
         fcnt <= '0;
      end else if (fcnt == FCNT_W'(FILT_CYCLES - 1)) begin
         fcnt <= '0;
         filt <= sync_q2;
      end else begin
         fcnt <= fcnt + 1'b1;
      end
   end
`else
   assign filt = sync_q2;
`endif

endmodule

// File: rtl/pad_cfg_sequencer.sv
// Per-pad shadow configuration with serial commit onto the pad configuration chain,
// plus synchronised pad inputs (glitch filter with `define PAD_INPUT_FILTER_EN).
//
// state     | meaning
// ----------+---------------------------------------------------------------
// IDLE      | accepting shadow writes, waiting for commit
// SHIFT_LO  | serial_clock low, serial_data presents the current bit
// SHIFT_HI  | serial_clock high, pad latches the bit
// LOAD      | serial_load strobe, all pads update together
// DONE      | one-cycle done pulse
module pad_cfg_sequencer
   import pad_cfg_pkg::*;
#(
   parameter int                  NUM_PADS    = 38,
   parameter int                  CFG_BITS    = 13,
   parameter int                  IDX_W       = 6,
   parameter int                  FILT_CYCLES = 3,
   parameter logic [CFG_BITS-1:0] RESET_CFG   = CFG_BITS'(RESET_CFG_DEFAULT)
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                wr_valid,
   output logic                wr_ready,
   input  logic [IDX_W-1:0]    wr_idx,
   input  logic [CFG_BITS-1:0] wr_data,
   input  logic                wr_bcast,
   input  logic                commit,
   output logic                busy,
   output logic                done,
   output logic                serial_clock,
   output logic                serial_data,
   output logic                serial_load,
   input  logic [NUM_PADS-1:0] pad_in_raw,
   output logic [NUM_PADS-1:0] pad_in
);

   localparam int CHAIN = NUM_PADS * CFG_BITS;
   localparam int CNT_W = $clog2(CHAIN);

   if ((2 ** IDX_W) < NUM_PADS || FILT_CYCLES < 1) begin : g_bad_params
      $error("pad_cfg_sequencer: IDX_W too small for NUM_PADS, or FILT_CYCLES < 1");
   end

   state_t            state;
   state_t            state_nxt;
   logic [CHAIN-1:0]  shadow;
   logic [CHAIN-1:0]  shadow_nxt;
   logic [CHAIN-1:0]  shreg;
   logic [CHAIN-1:0]  shreg_nxt;
   logic [CNT_W-1:0]  bit_cnt;
   logic [CNT_W-1:0]  bit_cnt_nxt;
   logic              wr_fire;
   logic              busy_nxt;
   logic              done_nxt;
   logic              sclk_nxt;
   logic              sdata_nxt;
   logic              sload_nxt;

   assign wr_ready = (state == ST_IDLE);
   assign wr_fire  = wr_valid & wr_ready;

   // Pad p lives at shadow[p*CFG_BITS +: CFG_BITS]; out-of-range indices match nothing.
   always_comb begin
      shadow_nxt = shadow;
      if (wr_fire) begin
         for (int p = 0; p < NUM_PADS; p++) begin
            if (wr_bcast || (wr_idx == IDX_W'(p))) begin
               shadow_nxt[p*CFG_BITS +: CFG_BITS] = wr_data;
            end
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         shadow <= {NUM_PADS{RESET_CFG}};
      end else begin
         shadow <= shadow_nxt;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state        <= ST_IDLE;
         shreg        <= '0;
         bit_cnt      <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
         serial_clock <= 1'b0;
         serial_data  <= 1'b0;
         serial_load  <= 1'b0;
      end else begin
         state        <= state_nxt;
         shreg        <= shreg_nxt;
         bit_cnt      <= bit_cnt_nxt;
         busy         <= busy_nxt;
         done         <= done_nxt;
         serial_clock <= sclk_nxt;
         serial_data  <= sdata_nxt;
         serial_load  <= sload_nxt;
      end
   end

   // Loading from shadow_nxt lets a write accepted alongside commit join the transfer.
   always_comb begin
      state_nxt   = state;
      shreg_nxt   = shreg;
      bit_cnt_nxt = bit_cnt;
      case (state)
         ST_IDLE: begin
            if (commit) begin
               state_nxt   = ST_SHIFT_LO;
               shreg_nxt   = shadow_nxt;
               bit_cnt_nxt = CNT_W'(CHAIN - 1);
            end
         end
         ST_SHIFT_LO: begin
            state_nxt = ST_SHIFT_HI;
         end
         ST_SHIFT_HI: begin
            if (bit_cnt == '0) begin
               state_nxt = ST_LOAD;
            end else begin
               state_nxt   = ST_SHIFT_LO;
               bit_cnt_nxt = bit_cnt - 1'b1;
               shreg_nxt   = {shreg[CHAIN-2:0], 1'b0};
            end
         end
         ST_LOAD: begin
            state_nxt = ST_DONE;
         end
         ST_DONE: begin
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // Outputs are decoded from the next state and registered, so pins never glitch.
   always_comb begin
      busy_nxt  = (state_nxt != ST_IDLE);
      done_nxt  = (state_nxt == ST_DONE);
      sclk_nxt  = (state_nxt == ST_SHIFT_HI);
      sload_nxt = (state_nxt == ST_LOAD);
      sdata_nxt = 1'b0;
      if (state_nxt == ST_SHIFT_LO || state_nxt == ST_SHIFT_HI) begin
         sdata_nxt = shreg_nxt[CHAIN-1];
      end
   end

   for (genvar g = 0; g < NUM_PADS; g++) begin : g_pad_in
      pad_in_filter #(
         .FILT_CYCLES (FILT_CYCLES)
      ) u_filt (
         .clock (clock),
         .reset (reset),
         .raw   (pad_in_raw[g]),
         .filt  (pad_in[g])
      );
   end

endmodule

// File: tb/tb_pad_cfg_sequencer.sv
// Scoreboard bench for pad_cfg_sequencer: stimulus pushes expected chain bits and
// done cycles, a negedge monitor pops and compares them as the DUT shifts.
module tb_pad_cfg_sequencer;

   localparam int NP      = 38;
   localparam int CB      = 13;
   localparam int IW      = 6;
   localparam int CHAIN   = NP * CB;
   localparam int XFER    = 2 * CHAIN + 2;
   localparam logic [CB-1:0] RST_CFG = 13'h1803;
`ifdef PAD_INPUT_FILTER_EN
   localparam int LAT = 5;
`else
   localparam int LAT = 2;
`endif

   logic          clock = 1'b0;
   logic          reset;
   logic          wr_valid;
   logic          wr_ready;
   logic [IW-1:0] wr_idx;
   logic [CB-1:0] wr_data;
   logic          wr_bcast;
   logic          commit;
   logic          busy;
   logic          done;
   logic          serial_clock;
   logic          serial_data;
   logic          serial_load;
   logic [NP-1:0] pad_in_raw;
   logic [NP-1:0] pad_in;

   pad_cfg_sequencer dut (
      .clock        (clock),
      .reset        (reset),
      .wr_valid     (wr_valid),
      .wr_ready     (wr_ready),
      .wr_idx       (wr_idx),
      .wr_data      (wr_data),
      .wr_bcast     (wr_bcast),
      .commit       (commit),
      .busy         (busy),
      .done         (done),
      .serial_clock (serial_clock),
      .serial_data  (serial_data),
      .serial_load  (serial_load),
      .pad_in_raw   (pad_in_raw),
      .pad_in       (pad_in)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   int            n_checks = 0;
   int            n_fail   = 0;
   bit            exp_bits[$];
   int            exp_done[$];
   int            done_cnt = 0;
   int            load_cnt = 0;
   logic [CB-1:0] mdl[NP];
   logic          prev_sclk = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   task automatic reset_model();
      for (int p = 0; p < NP; p++) mdl[p] = RST_CFG;
   endtask

   // Expected stream: pad NP-1 first, each word MSB first.
   task automatic push_expected();
      for (int p = NP - 1; p >= 0; p--) begin
         for (int b = CB - 1; b >= 0; b--) exp_bits.push_back(mdl[p][b]);
      end
      exp_done.push_back(cyc + XFER);
   endtask

   task automatic model_write(input int idx, input logic [CB-1:0] data, input bit bcast);
      if (bcast) begin
         for (int p = 0; p < NP; p++) mdl[p] = data;
      end else if (idx < NP) begin
         mdl[idx] = data;
      end
   endtask

   task automatic do_write(input int idx, input logic [CB-1:0] data, input bit bcast);
      wr_valid = 1'b1;
      wr_idx   = IW'(idx);
      wr_data  = data;
      wr_bcast = bcast;
      check("wr_ready_idle", wr_ready, 1);
      @(negedge clock);
      wr_valid = 1'b0;
      wr_bcast = 1'b0;
      model_write(idx, data, bcast);
   endtask

   task automatic do_commit(input bit with_wr, input int idx, input logic [CB-1:0] data);
      commit = 1'b1;
      if (with_wr) begin
         wr_valid = 1'b1;
         wr_idx   = IW'(idx);
         wr_data  = data;
         wr_bcast = 1'b0;
         model_write(idx, data, 1'b0);
      end
      push_expected();
      @(negedge clock);
      commit   = 1'b0;
      wr_valid = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int start;
      start = done_cnt;
      for (int i = 0; i < XFER + 40 && done_cnt == start; i++) @(negedge clock);
      check({name, "_done_seen"}, done_cnt - start, 1);
      check({name, "_stream_drained"}, exp_bits.size(), 0);
      @(negedge clock);
   endtask

   initial begin
      forever begin
         @(negedge clock);
         if (reset) begin
            prev_sclk = 1'b0;
         end else begin
            if (serial_clock && !prev_sclk) begin
               check("shift_expected", exp_bits.size() != 0, 1);
               check("busy_while_shifting", busy, 1);
               if (exp_bits.size() != 0) begin
                  int  idx;
                  bit  b;
                  idx = CHAIN - exp_bits.size();
                  b   = exp_bits.pop_front();
                  check($sformatf("serial_bit_%0d", idx), serial_data, b);
               end
            end
            if (serial_load) begin
               load_cnt++;
               check("load_after_last_bit", (exp_bits.size() == 0) && (exp_done.size() != 0), 1);
            end
            if (done) begin
               done_cnt++;
               check("done_expected", exp_done.size() != 0, 1);
               if (exp_done.size() != 0) check("done_cycle", cyc, exp_done.pop_front());
            end
            prev_sclk = serial_clock;
         end
      end
   end

   initial begin
      int lc;
      int dc;
      reset      = 1'b1;
      wr_valid   = 1'b0;
      wr_idx     = '0;
      wr_data    = '0;
      wr_bcast   = 1'b0;
      commit     = 1'b0;
      pad_in_raw = '0;
      reset_model();
      repeat (3) @(negedge clock);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_serial_clock", serial_clock, 0);
      check("rst_serial_data", serial_data, 0);
      check("rst_serial_load", serial_load, 0);
      check("rst_pad_in", pad_in, 0);
      check("rst_wr_ready", wr_ready, 1);
      reset = 1'b0;
      @(negedge clock);

      // Defaults straight out of reset.
      do_commit(0, 0, '0);
      wait_done("defaults");

      // Single pad write.
      do_write(5, 13'h0ABC, 0);
      do_commit(0, 0, '0);
      wait_done("pad5");

      // Broadcast, then writes and a commit while busy must be ignored.
      do_write(0, 13'h1FFF, 1);
      do_commit(0, 0, '0);
      repeat (20) @(negedge clock);
      wr_valid = 1'b1;
      wr_idx   = IW'(3);
      wr_data  = 13'h0000;
      commit   = 1'b1;
      check("wr_ready_busy", wr_ready, 0);
      check("busy_mid_xfer", busy, 1);
      @(negedge clock);
      wr_valid = 1'b0;
      commit   = 1'b0;
      wait_done("bcast");

      // Write and commit in the same cycle: the write is part of the transfer.
      do_commit(1, 10, 13'h0123);
      wait_done("commit_with_write");

      // Out-of-range index is dropped.
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      reset_model();
      @(negedge clock);
      do_write(45, 13'h0000, 0);
      do_commit(0, 0, '0);
      wait_done("idx45");

      // Reset in the middle of a transfer.
      do_write(2, 13'h0555, 0);
      lc = load_cnt;
      dc = done_cnt;
      do_commit(0, 0, '0);
      repeat (299) @(negedge clock);
      check("busy_before_abort", busy, 1);
      #2 reset = 1'b1;
      #1;
      check("abort_busy", busy, 0);
      check("abort_serial_clock", serial_clock, 0);
      check("abort_serial_load", serial_load, 0);
      check("abort_wr_ready", wr_ready, 1);
      exp_bits.delete();
      exp_done.delete();
      reset_model();
      @(negedge clock);
      reset = 1'b0;
      repeat (10) @(negedge clock);
      check("abort_no_load", load_cnt - lc, 0);
      check("abort_no_done", done_cnt - dc, 0);
      do_commit(0, 0, '0);
      wait_done("after_abort");

      // Pad input path: a 4-cycle level on pads 7 and 0.
      pad_in_raw[7] = 1'b1;
      pad_in_raw[0] = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clock);
         if (i == LAT - 1) check("pad_in_before_latency", pad_in, 0);
         if (i == LAT)     check("pad_in_at_latency", pad_in, 38'h0000000081);
         if (i == 4) pad_in_raw = '0;
      end
      repeat (10) @(negedge clock);
      check("pad_in_fall", pad_in, 0);

      // A 2-cycle pulse on pad 7.
      begin
         logic seen;
         seen = 1'b0;
         pad_in_raw[7] = 1'b1;
         for (int i = 1; i <= 10; i++) begin
            @(negedge clock);
            if (i == 2) pad_in_raw[7] = 1'b0;
            seen = seen | pad_in[7];
         end
`ifdef PAD_INPUT_FILTER_EN
         check("pulse_filtered", seen, 0);
`else
         check("pulse_passed", seen, 1);
`endif
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
